bin_to_gray_stepper: RTL
========================

// Module: bin_to_gray_stepper
// PURPOSE
// Transmit-side counterpart of the Gray-to-binary receive submodule. Accepts a binary
// target over a valid/ready handshake and walks a registered Gray-code output from the
// current position to that target, one code step per STEP_DIV clocks. Every step flips
// exactly one output bit. The output drives the Gray bus read by the receiver.
// PARAMETERS
// WIDTH     4  width of binary target and Gray output
// STEP_DIV  5  clocks per Gray step (>=1); 5 matches the receiver's 100 ns hold at 20 ns clock
// PORTS
// reloj        in   1      clock, all state on rising edge
// reset        in   1      asynchronous, active-high reset
// bin_in       in   WIDTH  binary target, sampled when load & ready
// load         in   1      request to start a walk to bin_in
// wrap_en      in   1      1: take shortest modular path; 0: monotonic up/down path. Sampled with load.
// ready        out  1      high in IDLE only
// gray_out     out  WIDTH  registered Gray code of internal position cur_bin
// gray_strobe  out  1      one-cycle pulse in the cycle gray_out takes a new value
// done         out  1      one-cycle pulse after walk completes; gray_out == gray(target)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, cur_bin=0, gray_out=0, div_cnt=0, gray_strobe=0,
//   done=0, ready=1. Reset mid-walk abandons the walk, and no done pulse is produced.
// - gray_out is always the registered value of cur_bin ^ (cur_bin >> 1).
// - FSM states are IDLE, WAIT and DONE.
//   IDLE: ready=1. On an edge with load=1, capture tgt=bin_in and dir.
//     If tgt==cur_bin, go to DONE with no step.
//     Otherwise set div_cnt=0 and go to WAIT.
//   WAIT: on each edge, if div_cnt==STEP_DIV-1, step cur_bin by +1 or -1 mod 2^WIDTH,
//     set div_cnt=0 and assert gray_strobe for the following cycle.
//     If the new cur_bin==tgt, go to DONE. Otherwise stay in WAIT with div_cnt+1.
//   DONE: done=1 for exactly one cycle, then go to IDLE.
// - Direction is decided at load.
//   wrap_en=0: up if tgt>cur_bin, else down. Never wraps through 0 or 2^WIDTH-1.
//   wrap_en=1: up_dist=(tgt-cur_bin) mod 2^WIDTH, down_dist=2^WIDTH-up_dist.
//     Go up if up_dist<=down_dist (a tie goes up), else down. Wrapping 15->0 or 0->15 is legal.
// - Timing: load accepted at edge E0. Step k lands at edge E0+k*STEP_DIV.
//   gray_strobe is high in the cycle after each step edge.
//   done is high in the cycle after the last step edge, together with the last strobe.
//   ready returns one cycle after done.
// - load while ready=0 is ignored, with no queueing. bin_in and wrap_en are don't-care outside
//   the load edge.
// - A walk needs N steps and N*STEP_DIV+1 cycles from E0 until ready rises again.
// - With STEP_DIV=1, a step occurs every clock and gray_strobe stays high for the whole walk.
// TESTING
// - Reset asserted mid-walk (cur_bin=2) -> gray_out=0000, ready=1, done=0 immediately, with no
//   clock edge needed.
// - From 0, load bin_in=3, wrap_en=0, STEP_DIV=5 -> gray_out 0001@E0+5, 0011@E0+10, 0010@E0+15.
//   Expect 3 strobes, done in the cycle after E0+15, ready after.
// - From 3, load bin_in=3 -> no strobe, done one cycle after E0, gray_out stays 0010.
// - From 1, load 14, wrap_en=1 -> goes down: 0000, 1000, 1001, then done.
//   Same stimulus with wrap_en=0 -> 13 up-steps ending at 1001.
// - From 0, load 8, wrap_en=1 (tie) -> goes up through 0001..1100, 8 steps.
//   Check every consecutive gray_out pair differs in exactly 1 bit.
// - Pulse load with bin_in=7 during a walk to 5 -> ignored; walk ends at 0111^... i.e.
//   gray(5)=0111, and a single done pulse is produced.

Source files
------------

// File: rtl/bin_to_gray_stepper.sv
// Walks a registered Gray-code output from the current position to a loaded binary
// target, one single-bit Gray step every STEP_DIV clocks.
module bin_to_gray_stepper #(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 5
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             load,
    input  logic             wrap_en,
    output logic             ready,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_strobe,
    output logic             done
);

    localparam int               CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_bin_q, cur_bin_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             up_q, up_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] gray_q;
    logic             strobe_q, strobe_d;
    logic [WIDTH-1:0] step_bin;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Modular mode compares the up distance against its complement; a tie goes up.
    function automatic logic pick_up(input logic [WIDTH-1:0] cur,
                                     input logic [WIDTH-1:0] tgt,
                                     input logic             wrap);
        logic [WIDTH-1:0] up_dist;
        logic [WIDTH:0]   down_dist;
        if (!wrap) begin
            return tgt > cur;
        end
        up_dist   = tgt - cur;
        down_dist = {1'b1, {WIDTH{1'b0}}} - {1'b0, up_dist};
        return {1'b0, up_dist} <= down_dist;
    endfunction

    assign step_bin = up_q ? (cur_bin_q + BIN_ONE) : (cur_bin_q - BIN_ONE);

    always_comb begin
        state_d   = state_q;
        cur_bin_d = cur_bin_q;
        tgt_d     = tgt_q;
        up_d      = up_q;
        div_cnt_d = div_cnt_q;
        strobe_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    tgt_d     = bin_in;
                    up_d      = pick_up(cur_bin_q, bin_in, wrap_en);
                    div_cnt_d = '0;
                    state_d   = (bin_in == cur_bin_q) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (div_cnt_q == CNT_LAST) begin
                    cur_bin_d = step_bin;
                    div_cnt_d = '0;
                    strobe_d  = 1'b1;
                    if (step_bin == tgt_q) begin
                        state_d = DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_bin_q <= '0;
            tgt_q     <= '0;
            up_q      <= 1'b0;
            div_cnt_q <= '0;
            gray_q    <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_bin_q <= cur_bin_d;
            tgt_q     <= tgt_d;
            up_q      <= up_d;
            div_cnt_q <= div_cnt_d;
            gray_q    <= to_gray(cur_bin_d);
            strobe_q  <= strobe_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign gray_out    = gray_q;
    assign gray_strobe = strobe_q;

endmodule
